// File: rtl/fd_circle_fetch.sv
// -----------------------------------------------------------------------------
// fd_circle_fetch
//
// Streaming front end for the FAST-9 corner datapath. Takes a raster-order
// 8-bit pixel stream and keeps six image lines (line buffers) plus a 7x7
// window. For every pixel whose radius-3 Bresenham circle lies fully inside
// the image it presents the centre pixel and the 16 circle pixels.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   inPixel/inSof       : input pixel and start-of-frame flag
//   inValid/inReady     : input handshake (inReady = outReady | ~outValid)
//   refPixel            : circle centre pixel
//   adjPixel            : circle position k (1..16) at bits [135-8k : 128-8k]
//   outValid/outReady   : output handshake
//   outRow/outCol       : centre coordinates (only with FD_COORD_EN defined)
//
// Optional feature macro: FD_COORD_EN adds the outRow/outCol ports.
// -----------------------------------------------------------------------------
module fd_circle_fetch #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     inPixel,
    input  logic           inSof,
    input  logic           inValid,
    output logic           inReady,
    output logic [7:0]     refPixel,
    output logic [127:0]   adjPixel,
    output logic           outValid,
    input  logic           outReady
`ifdef FD_COORD_EN
    ,
    output logic [CW-1:0]  outRow,
    output logic [CW-1:0]  outCol
`endif
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    // Circle offsets, clockwise from the top (position 1 first).
    localparam int CDX [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int CDY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    logic            accept;
    logic [CW-1:0]   col_q, col_d, row_q, row_d;
    logic [CW-1:0]   pos_col, pos_row;
    logic [2:0]      fill_q, fill_d, fill_cur;
    logic            emit;
    logic [AW-1:0]   lb_addr;
    logic [7:0]      lb_rd   [6];
    logic [7:0]      new_col [7];
    logic [7:0]      win_q   [7][7];
    logic [7:0]      win_d   [7][7];
    logic [127:0]    circ_bus;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      ref_q, ref_d;
    logic [127:0]    adj_q, adj_d;

    assign inReady = outReady | ~out_valid_q;
    assign accept  = inValid & inReady;

    // Position of the pixel on the input port; an SOF beat is always (0,0).
    // fill counts completed rows since reset/SOF, saturating at 6.
    always_comb begin
        pos_col  = inSof ? '0 : col_q;
        pos_row  = inSof ? '0 : row_q;
        fill_cur = inSof ? 3'd0 : fill_q;
        emit     = accept && (pos_row >= CW'(6)) && (pos_col >= CW'(6)) && (fill_cur == 3'd6);
        col_d    = col_q;
        row_d    = row_q;
        fill_d   = fill_q;
        if (accept) begin
            if (pos_col == CW'(IMG_W - 1)) begin
                col_d  = '0;
                row_d  = (pos_row == CW'(IMG_H - 1)) ? '0 : pos_row + CW'(1);
                fill_d = (fill_cur == 3'd6) ? 3'd6 : fill_cur + 3'd1;
            end else begin
                col_d  = pos_col + CW'(1);
                row_d  = pos_row;
                fill_d = fill_cur;
            end
        end
    end

    assign lb_addr = pos_col[AW-1:0];

    // Six line buffers chained as a delay line: buffer 0 stores the incoming
    // pixel, buffer k stores what buffer k-1 held for this column.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_line
            logic [7:0] mem [IMG_W];
            assign lb_rd[gi] = mem[lb_addr];
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (accept) mem[lb_addr] <= inPixel;
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (accept) mem[lb_addr] <= lb_rd[gi-1];
                end
            end
        end

        // New rightmost window column, oldest line at the top.
        for (gi = 0; gi < 6; gi++) begin : g_newcol
            assign new_col[gi] = lb_rd[5-gi];
        end
    endgenerate
    assign new_col[6] = inPixel;

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int y = 0; y < 7; y++) begin
                for (int x = 0; x < 6; x++) begin
                    win_d[y][x] = win_q[y][x+1];
                end
                win_d[y][6] = new_col[y];
            end
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    // Circle taps come from the window as it will be after this beat, so the
    // result is registered in the same cycle as the completing pixel.
    generate
        for (gi = 0; gi < 16; gi++) begin : g_circ
            assign circ_bus[127-8*gi -: 8] = win_d[3+CDY[gi]][3+CDX[gi]];
        end
    endgenerate

    always_comb begin
        out_valid_d = out_valid_q;
        ref_d       = ref_q;
        adj_d       = adj_q;
        if (emit) begin
            out_valid_d = 1'b1;
            ref_d       = win_d[3][3];
            adj_d       = circ_bus;
        end else if (out_valid_q && outReady) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            ref_q       <= '0;
            adj_q       <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            ref_q       <= ref_d;
            adj_q       <= adj_d;
        end
    end

    assign outValid = out_valid_q;
    assign refPixel = ref_q;
    assign adjPixel = adj_q;

`ifdef FD_COORD_EN
    logic [CW-1:0] out_row_q, out_row_d, out_col_q, out_col_d;

    always_comb begin
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        if (emit) begin
            out_row_d = pos_row - CW'(3);
            out_col_d = pos_col - CW'(3);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_row_q <= '0;
            out_col_q <= '0;
        end else begin
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
        end
    end

    assign outRow = out_row_q;
    assign outCol = out_col_q;
`endif

endmodule

// File: tb/tb_fd_circle_fetch.sv
// -----------------------------------------------------------------------------
// tb_fd_circle_fetch
//
// Self-checking bench for fd_circle_fetch on an 8x8 image. The reference model
// stores every accepted pixel in an image array indexed by (row, col) and
// derives each expected result directly from the circle offsets; a small
// handshake model tracks which result the DUT must be holding each cycle.
// Set FD_COORD_EN to also check outRow/outCol.
// -----------------------------------------------------------------------------
module tb_fd_circle_fetch;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     inPixel = '0;
    logic           inSof = 1'b0;
    logic           inValid = 1'b0;
    logic           outReady = 1'b0;
    logic           inReady;
    logic [7:0]     refPixel;
    logic [127:0]   adjPixel;
    logic           outValid;
`ifdef FD_COORD_EN
    logic [CW-1:0]  outRow, outCol;
`endif

    fd_circle_fetch #(.IMG_W(W), .IMG_H(H), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .inPixel  (inPixel),
        .inSof    (inSof),
        .inValid  (inValid),
        .inReady  (inReady),
        .refPixel (refPixel),
        .adjPixel (adjPixel),
        .outValid (outValid),
        .outReady (outReady)
`ifdef FD_COORD_EN
        ,
        .outRow   (outRow),
        .outCol   (outCol)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]   src [H][W];
    logic [7:0]   img [H][W];
    logic         m_valid;
    logic [7:0]   m_ref;
    logic [127:0] m_adj;
    int           m_row, m_col;
    int           ready_mode;
    int           delivered;

    int dxs [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    int dys [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] circle_of(input int r, input int c);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[127-8*k -: 8] = img[r+dys[k]][c+dxs[k]];
        return v;
    endfunction

    task automatic fill_pattern();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) src[r][c] = 8'(r*16 + c);
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) src[r][c] = 8'($urandom);
    endtask

    // One clock cycle: drive inputs at posedge+1, predict, check at posedge+1.
    task automatic step(input logic v, input logic [7:0] p, input logic s,
                        input int r, input int c, output logic acc);
        logic rdy, exp_rdy;
        case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'b0;
            default: rdy = ($urandom_range(0, 3) != 0);
        endcase
        inValid  = v;
        inPixel  = p;
        inSof    = s;
        outReady = rdy;
        #1;
        exp_rdy = rdy | ~m_valid;
        chk("inReady", inReady, exp_rdy);
        acc = v & exp_rdy;
        if (outValid === 1'b1 && rdy) begin
            delivered++;
`ifdef FD_COORD_EN
            $display("out %0d: centre=(%0d,%0d) ref=%02h adj=%032h", delivered, outRow, outCol, refPixel, adjPixel);
`else
            $display("out %0d: ref=%02h adj=%032h", delivered, refPixel, adjPixel);
`endif
        end
        if (acc) img[r][c] = p;
        if (acc && r >= 6 && c >= 6) begin
            m_valid = 1'b1;
            m_ref   = img[r-3][c-3];
            m_adj   = circle_of(r-3, c-3);
            m_row   = r - 3;
            m_col   = c - 3;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("outValid", outValid, m_valid);
        if (m_valid) begin
            chk("refPixel", refPixel, m_ref);
            chk("adjPixel", adjPixel, m_adj);
`ifdef FD_COORD_EN
            chk("outRow", outRow, CW'(m_row));
            chk("outCol", outCol, CW'(m_col));
`endif
        end
    endtask

    // Send raster indices lo..hi of src; gap 0 none, 1 one idle cycle, 2 random.
    task automatic send_range(input int lo, input int hi, input int gap);
        logic acc;
        int   tries, r, c, idle;
        for (int i = lo; i <= hi; i++) begin
            r = i / W;
            c = i % W;
            idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < idle; g++) step(1'b0, 8'($urandom), 1'($urandom), 0, 0, acc);
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 64) begin
                step(1'b1, src[r][c], (i == 0), r, c, acc);
                tries++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $error("FAIL accept_timeout: observed=no accept expected=accept at (%0d,%0d)", r, c);
                return;
            end
        end
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        ready_mode = 0;
        while (m_valid && n < 20) begin
            step(1'b0, 8'h00, 1'b0, 0, 0, acc);
            n++;
        end
        step(1'b0, 8'h00, 1'b0, 0, 0, acc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        m_valid = 1'b0; m_ref = '0; m_adj = '0; m_row = 0; m_col = 0;
        ready_mode = 0; delivered = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outValid", outValid, 1'b0);
        chk("rst_refPixel", refPixel, 8'h00);
        chk("rst_adjPixel", adjPixel, 128'h0);
        chk("rst_inReady", inReady, 1'b1);
`ifdef FD_COORD_EN
        chk("rst_outRow", outRow, '0);
        chk("rst_outCol", outCol, '0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Pattern frame, full rate, with known first result
        fill_pattern();
        delivered = 0;
        send_range(0, 6*W + 6, 0);
        chk("s1_ref", refPixel, 8'h33);
        chk("s1_pos1", adjPixel[127:120], 8'h03);
        chk("s1_pos5", adjPixel[95:88], 8'h36);
        chk("s1_pos9", adjPixel[63:56], 8'h63);
        chk("s1_pos16", adjPixel[7:0], 8'h02);
        send_range(6*W + 7, W*H - 1, 0);
        drain();
        chk("s1_count", delivered, 4);

        // Same frame with inValid low every other cycle
        delivered = 0;
        send_range(0, W*H - 1, 1);
        drain();
        chk("s2_count", delivered, 4);

        // Back-pressure for 5 cycles after the first result
        delivered = 0;
        send_range(0, 6*W + 6, 0);
        ready_mode = 1;
        repeat (5) step(1'b1, src[6][7], 1'b0, 6, 7, acc);
        chk("s3_stall_ref", refPixel, 8'h33);
        ready_mode = 0;
        send_range(6*W + 7, W*H - 1, 0);
        drain();
        chk("s3_count", delivered, 4);

        // Two back-to-back frames with different content
        delivered = 0;
        send_range(0, W*H - 1, 0);
        fill_random();
        send_range(0, W*H - 1, 0);
        drain();
        chk("s4_count", delivered, 8);

        // SOF arriving at row 5 of a frame
        delivered = 0;
        fill_pattern();
        send_range(0, 5*W + 3, 0);
        fill_random();
        send_range(0, W*H - 1, 0);
        drain();
        chk("s5_count", delivered, 4);

        // Reset pulsed mid-frame while a result is held
        fill_pattern();
        send_range(0, 6*W + 6, 0);
        #1;
        rst = 1'b1;
        #1;
        chk("s6_rst_outValid", outValid, 1'b0);
        chk("s6_rst_inReady", inReady, 1'b1);
        chk("s6_rst_refPixel", refPixel, 8'h00);
        m_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        delivered = 0;
        send_range(0, W*H - 1, 0);
        drain();
        chk("s6_count", delivered, 4);

        // Random frames with random gaps and random back-pressure
        for (int f = 0; f < 3; f++) begin
            delivered = 0;
            fill_random();
            ready_mode = 2;
            send_range(0, W*H - 1, 2);
            drain();
            chk("s7_count", delivered, 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fd_circle_fetch.md
# fd_circle_fetch

Streaming front end for the FAST-9 corner datapath. Accepts a raster-order 8-bit pixel stream and buffers six image lines plus a 7×7 window. For every pixel whose radius-3 Bresenham circle lies fully inside the image, it presents the centre pixel and the 16 circle pixels in the packed order the corner datapath consumes (`refPixel`, `adjPixel`). It sits between the pixel source (camera/DMA) and the datapath, and adds a ready/valid handshake on both sides.

## Interface
- `IMG_W`, 640: image width in pixels (≥7).
- `IMG_H`, 480: image height in lines (≥7).
- `CW`, 10: coordinate counter width; must satisfy 2^CW ≥ max(IMG_W, IMG_H).
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `inPixel` input 8: incoming pixel, raster order.
- `inSof` input 1: marks the first pixel of a frame. Sampled only on an accepted beat.
- `inValid` input 1: `inPixel`/`inSof` are valid.
- `inReady` output 1: block can accept a beat; `inReady = outReady | ~outValid`.
- `refPixel` output 8: circle centre pixel.
- `adjPixel` output 128: circle position k (1..16) at bits [135-8k : 128-8k].
- `outValid` output 1: `refPixel`/`adjPixel` are valid.
- `outReady` input 1: downstream accepts the output.
- `outRow`, `outCol` output CW each: centre coordinates. Present only with `FD_COORD_EN`.

## Operation
- A beat is accepted when `inValid & inReady`. Nothing advances on cycles without an accepted beat: counters, line buffers, window and output registers all hold.
- Column counter `col` (0..IMG_W-1) and row counter `row` (0..IMG_H-1) give the position of the accepted pixel. `col` wraps to 0 and `row` increments. At (IMG_H-1, IMG_W-1) both wrap to 0.
- An accepted beat with `inSof=1` forces that pixel to position (0,0), regardless of the counter values. Subsequent pixels count from there.
- Line buffers: six IMG_W×8 memories chained as a delay line, addressed by `col`. Each has one read and one write per accepted beat, read-before-write.
- Window: 7 rows × 7 columns of 8-bit shift registers. On each accepted beat every row shifts left by one. The new rightmost column is {line5..line0 read data, `inPixel`} (oldest at the top).
- Circle offsets (dx, dy) from the centre, clockwise from the top:
  - 1:(0,-3) 2:(1,-3) 3:(2,-2) 4:(3,-1) 5:(3,0) 6:(3,1) 7:(2,2) 8:(1,3)
  - 9:(0,3) 10:(-1,3) 11:(-2,2) 12:(-3,1) 13:(-3,0) 14:(-3,-1) 15:(-2,-2) 16:(-1,-3)
- Accepting pixel (r, c) completes the window centred at (r-3, c-3).
- A result is emitted only if r ≥ 6 and c ≥ 6, and at least 6 rows have been accepted since the last reset or `inSof`. Windows that straddle a row wrap are therefore never emitted.
- Output register: loaded on an accepted beat that completes an emittable window; `outValid` is then set.
- `outValid` clears on `outValid & outReady` unless a new result loads in the same cycle.
- `refPixel`/`adjPixel` are stable while `outValid & ~outReady`.
- An `inSof` accepted mid-frame drops any partial-frame state. Line buffer contents are stale but unused until 6 new rows have arrived.

## Timing
- Reset values: `outValid=0`, `refPixel=0`, `adjPixel=0`, `outRow=0`, `outCol=0`; counters 0; row-fill count 0. The window and line buffers need no reset.
- `inReady` is combinational from `outReady` and `outValid`, so it is 1 out of reset.
- Latency: the result for centre (r-3, c-3) is valid in the cycle after pixel (r, c) is accepted.
- Throughput: one pixel per cycle while `outReady=1`.
- Back-pressure: `outValid=1` with `outReady=0` holds `inReady=0`. No beat is lost or duplicated.
- Reset asserted mid-frame: all state clears asynchronously and the bench restarts with `inSof`.

## Configuration
- `FD_COORD_EN` defined: `outRow`/`outCol` ports exist and are loaded with `row-3`/`col-3` alongside `refPixel`.
- `FD_COORD_EN` undefined: those ports and their registers are absent. All other behaviour is identical.

## Test plan
- IMG_W=IMG_H=8, pixel = row·16+col, `inSof` on the first pixel, `outReady=1`:
  - exactly 4 outputs, centres (3,3) (3,4) (4,3) (4,4);
  - first output `refPixel`=0x33, `adjPixel`[127:120]=0x03 (pos 1), [95:88]=0x36 (pos 5), [63:56]=0x63 (pos 9), [7:0]=0x02 (pos 16).
- Same frame with `inValid` deasserted every other cycle: identical output sequence and values, each valid one cycle after its completing beat.
- `outReady` held low for 5 cycles after the first output: `refPixel`/`adjPixel` stable, `inReady=0`, all 4 outputs delivered in order with none skipped.
- Frame 2 sent immediately after frame 1 using a different pattern: the 4 outputs match frame 2 only. No window mixes data from the two frames.
- `inSof` asserted at row 5 of a frame: no output until 6 further rows have been accepted, then centres restart at (3,3).
- `rst` pulsed mid-frame: `outValid` drops to 0 asynchronously, `inReady=1`, and a following full frame reproduces the results of the first scenario.
- With `FD_COORD_EN`: `outRow`/`outCol` equal the expected centres in every scenario above.
